// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter
//   Shares one DMA engine among NUM_CH requesters. A round-robin arbiter
//   grants one transfer at a time. Each channel gets a done or error strobe
//   back. A watchdog aborts an engine that stalls in BUSY.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for enable && a request; winner latched on exit
//   START | engine start issued (dma_start is visible the following cycle)
//   BUSY  | waiting for dma_done; watchdog counting
//   DONE  | per-channel strobe visible, grant released on exit
//
// Ports
//   clk, rst             system clock, asynchronous active-high reset
//   enable               allow new grants (an in-flight transfer always completes)
//   req                  per-channel request level
//   req_addr, req_len    per-channel packed address / word count
//   gnt                  one-hot grant, held START..DONE
//   dma_start            single-cycle engine start strobe
//   dma_addr, dma_len    latched address / length of the granted channel
//   dma_done, dma_err    engine completion strobe and error qualifier
//   dma_abort            single-cycle abort strobe on watchdog expiry
//   ch_done, ch_err      single-cycle per-channel result strobes
//   dbg_state, dbg_xfers FSM encoding and completed-transfer count
module dma_channel_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int LEN_W   = 16,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*LEN_W-1:0]  req_len,
    output logic [NUM_CH-1:0]        gnt,
    output logic                     dma_start,
    output logic [ADDR_W-1:0]        dma_addr,
    output logic [LEN_W-1:0]         dma_len,
    input  logic                     dma_done,
    input  logic                     dma_err,
    output logic                     dma_abort,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [1:0]               dbg_state,
    output logic [15:0]              dbg_xfers
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        BUSY  = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  ptr, winner;
    logic              found;
    logic [WD_W-1:0]   watchdog;
    logic              wd_hit;
    logic [ADDR_W-1:0] win_addr;
    logic [LEN_W-1:0]  win_len;
    logic [NUM_CH-1:0] win_onehot;
    logic              do_grant, finish, finish_ok, wd_expire;

    // base + step modulo NUM_CH, with step < NUM_CH
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        return PTR_W'(sum);
    endfunction

    // The first request at or above the pointer wins, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[wrap_inc(ptr, i)]) begin
                found  = 1'b1;
                winner = wrap_inc(ptr, i);
            end
        end
    end

    assign win_addr   = req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign win_len    = req_len[int'(winner)*LEN_W +: LEN_W];
    assign win_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
    assign wd_hit     = WD_EN && (watchdog == WD_LAST);
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        finish    = 1'b0;
        finish_ok = 1'b0;
        wd_expire = 1'b0;
        case (state)
            IDLE: begin
                if (enable && found) begin
                    do_grant  = 1'b1;
                    // A zero-length transfer never touches the engine.
                    state_nxt = (win_len == '0) ? DONE : START;
                end
            end
            START: state_nxt = BUSY;
            BUSY: begin
                // dma_done takes priority over a simultaneous watchdog expiry.
                if (dma_done) begin
                    finish    = 1'b1;
                    finish_ok = !dma_err;
                    state_nxt = DONE;
                end else if (wd_hit) begin
                    finish    = 1'b1;
                    wd_expire = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            dma_start <= 1'b0;
            dma_addr  <= '0;
            dma_len   <= '0;
            dma_abort <= 1'b0;
            ch_done   <= '0;
            ch_err    <= '0;
            dbg_xfers <= '0;
            ptr       <= '0;
            watchdog  <= '0;
        end else begin
            dma_start <= (state == START);
            dma_abort <= wd_expire;
            ch_done   <= '0;
            ch_err    <= '0;

            if (do_grant) begin
                gnt      <= win_onehot;
                dma_addr <= win_addr;
                dma_len  <= win_len;
                ptr      <= wrap_inc(winner, 1);
                if (win_len == '0) ch_done <= win_onehot;
            end

            if (finish) begin
                if (finish_ok) ch_done <= gnt;
                else           ch_err  <= gnt;
            end

            if (state != DONE && state_nxt == DONE) dbg_xfers <= dbg_xfers + 16'd1;

            if (state == BUSY) watchdog <= watchdog + 1'b1;

            if (state == DONE) begin
                gnt      <= '0;
                watchdog <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter (NUM_CH=4, TIMEOUT=100).
module tb_dma_channel_arbiter;

    localparam int NUM_CH  = 4;
    localparam int LEN_W   = 16;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 100;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*LEN_W-1:0]  req_len;
    logic [NUM_CH-1:0]        gnt;
    logic                     dma_start;
    logic [ADDR_W-1:0]        dma_addr;
    logic [LEN_W-1:0]         dma_len;
    logic                     dma_done;
    logic                     dma_err;
    logic                     dma_abort;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH-1:0]        ch_err;
    logic [1:0]               dbg_state;
    logic [15:0]              dbg_xfers;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;
    int m_xfers  = 0;

    dma_channel_arbiter #(
        .NUM_CH(NUM_CH), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .req_addr(req_addr), .req_len(req_len), .gnt(gnt),
        .dma_start(dma_start), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_done(dma_done), .dma_err(dma_err), .dma_abort(dma_abort),
        .ch_done(ch_done), .ch_err(ch_err),
        .dbg_state(dbg_state), .dbg_xfers(dbg_xfers)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // Round-robin rule: first requester at or after pointer p, cyclically.
    function automatic int pick(input logic [NUM_CH-1:0] r, input int p);
        for (int k = 0; k < NUM_CH; k++)
            if (r[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
        return -1;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input int c);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; req = '0; dma_done = 1'b0; dma_err = 1'b0;
        req_addr = '0; req_len = '0;
        cyc(); cyc();
        rst = 1'b0;
        m_ptr = 0; m_xfers = 0;
        cyc();
    endtask

    task automatic wait_start(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < budget && !ok) begin
            cyc();
            n++;
            if (dma_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; req = 4'hF; dma_done = 1'b1; dma_err = 1'b1;
        req_addr = {$urandom, $urandom, $urandom, $urandom};
        req_len  = {$urandom, $urandom};
        cyc(); cyc();
        checks++; if ({gnt, dma_start, dma_abort, ch_done, ch_err, dbg_state} !== '0) begin
            failures++; $display("FAIL reset_ctrl got=%0h exp=0", {gnt, dma_start, dma_abort, ch_done, ch_err, dbg_state}); end
        checks++; if (dma_addr !== '0) begin
            failures++; $display("FAIL reset_addr got=%0h exp=0", dma_addr); end
        checks++; if (dma_len !== '0) begin
            failures++; $display("FAIL reset_len got=%0h exp=0", dma_len); end
        checks++; if (dbg_xfers !== 16'd0) begin
            failures++; $display("FAIL reset_xfers got=%0d exp=0", dbg_xfers); end
        req = '0; dma_done = 1'b0; dma_err = 1'b0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        do_reset();
        req_addr[31:0] = 32'h0000_1000;
        req_len[15:0]  = 16'd16;
        req = 4'b0001;
        cyc();
        checks++; if (dma_start !== 1'b0) begin
            failures++; $display("FAIL single_start_early got=%0b exp=0", dma_start); end
        cyc();
        checks++; if (dma_start !== 1'b1) begin
            failures++; $display("FAIL single_start_latency got=%0b exp=1", dma_start); end
        checks++; if (dma_addr !== 32'h1000) begin
            failures++; $display("FAIL single_addr got=%0h exp=1000", dma_addr); end
        checks++; if (dma_len !== 16'd16) begin
            failures++; $display("FAIL single_len got=%0d exp=16", dma_len); end
        checks++; if (gnt !== 4'b0001) begin
            failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        cyc();
        checks++; if (dma_start !== 1'b0) begin
            failures++; $display("FAIL single_start_width got=%0b exp=0", dma_start); end
        cyc();
        dma_done = 1'b1;
        cyc();
        dma_done = 1'b0;
        checks++; if (ch_done !== 4'b0001 || ch_err !== 4'b0000) begin
            failures++; $display("FAIL single_strobe got done=%b err=%b exp done=0001 err=0000", ch_done, ch_err); end
        checks++; if (dbg_xfers !== 16'd1) begin
            failures++; $display("FAIL single_xfers got=%0d exp=1", dbg_xfers); end
        req = '0;
        cyc();
        checks++; if (gnt !== 4'b0000 || ch_done !== 4'b0000 || dbg_state !== 2'b00) begin
            failures++; $display("FAIL single_release got gnt=%b done=%b st=%0d exp 0/0/0", gnt, ch_done, dbg_state); end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n;
        bit ok;
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            req_addr[c*ADDR_W +: ADDR_W] = $urandom;
            req_len[c*LEN_W +: LEN_W]    = 16'($urandom_range(1, 500));
        end
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_start(10, n, ok);
            checks++; if (!ok) begin
                failures++; $display("FAIL rr_no_start iter=%0d got none exp start", t); end
            checks++; if (gnt !== onehot(exp_order[t]) || pick(4'b1111, m_ptr) != exp_order[t]) begin
                failures++; $display("FAIL rr_order iter=%0d got=%b exp=%b", t, gnt, onehot(exp_order[t])); end
            checks++; if (dma_addr !== req_addr[exp_order[t]*ADDR_W +: ADDR_W]) begin
                failures++; $display("FAIL rr_addr iter=%0d got=%0h exp=%0h", t, dma_addr, req_addr[exp_order[t]*ADDR_W +: ADDR_W]); end
            m_ptr = (exp_order[t] + 1) % NUM_CH;
            repeat (5) cyc();
            dma_done = 1'b1;
            cyc();
            dma_done = 1'b0;
            m_xfers++;
            checks++; if (ch_done !== onehot(exp_order[t])) begin
                failures++; $display("FAIL rr_done iter=%0d got=%b exp=%b", t, ch_done, onehot(exp_order[t])); end
        end
        req = '0;
        cyc();
        checks++; if (dbg_xfers !== 16'(m_xfers)) begin
            failures++; $display("FAIL rr_xfers got=%0d exp=%0d", dbg_xfers, m_xfers); end
    endtask

    task automatic test_watchdog();
        int n, busy;
        bit ok, early;
        do_reset();
        req_len[2*LEN_W +: LEN_W] = 16'd8;
        req = 4'b0100;
        wait_start(10, n, ok);
        busy = 0; early = 1'b0;
        while (dbg_state === 2'b10 && busy < 200) begin
            if (dma_abort === 1'b1) early = 1'b1;
            busy++;
            cyc();
        end
        checks++; if (busy != TIMEOUT || early) begin
            failures++; $display("FAIL wd_busy_cycles got=%0d early=%0b exp=%0d", busy, early, TIMEOUT); end
        checks++; if (dma_abort !== 1'b1) begin
            failures++; $display("FAIL wd_abort got=%0b exp=1", dma_abort); end
        checks++; if (ch_err !== 4'b0100 || ch_done !== 4'b0000) begin
            failures++; $display("FAIL wd_strobe got err=%b done=%b exp err=0100 done=0000", ch_err, ch_done); end
        req = '0;
        cyc();
        checks++; if (dma_abort !== 1'b0 || dbg_state !== 2'b00) begin
            failures++; $display("FAIL wd_return got abort=%0b st=%0d exp 0/0", dma_abort, dbg_state); end

        // DMA_DONE on the very cycle the watchdog would fire
        req_len[3*LEN_W +: LEN_W] = 16'd9;
        req = 4'b1000;
        wait_start(10, n, ok);
        busy = 1;
        while (busy < TIMEOUT) begin
            cyc();
            busy++;
        end
        dma_done = 1'b1;
        cyc();
        dma_done = 1'b0;
        checks++; if (dma_abort !== 1'b0 || ch_done !== 4'b1000 || ch_err !== 4'b0000) begin
            failures++; $display("FAIL wd_tie got abort=%0b done=%b err=%b exp 0/1000/0000", dma_abort, ch_done, ch_err); end
        req = '0;
        cyc();
        checks++; if (dbg_xfers !== 16'd2) begin
            failures++; $display("FAIL wd_xfers got=%0d exp=2", dbg_xfers); end
    endtask

    task automatic test_err_zero();
        int n;
        bit ok, bad;
        do_reset();
        req_len[1*LEN_W +: LEN_W] = 16'd5;
        req = 4'b0010;
        wait_start(10, n, ok);
        cyc();
        dma_done = 1'b1; dma_err = 1'b1;
        cyc();
        dma_done = 1'b0; dma_err = 1'b0;
        checks++; if (ch_err !== 4'b0010 || ch_done !== 4'b0000) begin
            failures++; $display("FAIL err_strobe got err=%b done=%b exp err=0010 done=0000", ch_err, ch_done); end
        req = '0;
        cyc();
        req_len[3*LEN_W +: LEN_W] = 16'd0;
        req = 4'b1000;
        cyc();
        checks++; if (ch_done !== 4'b1000 || ch_err !== 4'b0000 || dbg_state !== 2'b11) begin
            failures++; $display("FAIL zero_len got done=%b err=%b st=%0d exp 1000/0000/3", ch_done, ch_err, dbg_state); end
        req = '0;
        bad = (dma_start !== 1'b0);
        repeat (4) begin
            cyc();
            if (dma_start !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin
            failures++; $display("FAIL zero_len_start got start=1 exp no start"); end
        checks++; if (dbg_xfers !== 16'd2) begin
            failures++; $display("FAIL err_zero_xfers got=%0d exp=2", dbg_xfers); end
    endtask

    task automatic test_enable();
        int n;
        bit ok, bad;
        do_reset();
        req_len[15:0]  = 16'd3;
        req_len[31:16] = 16'd4;
        req = 4'b0011;
        wait_start(10, n, ok);
        checks++; if (!ok || gnt !== 4'b0001) begin
            failures++; $display("FAIL en_first got ok=%0b gnt=%b exp 1/0001", ok, gnt); end
        cyc();
        enable = 1'b0;
        cyc(); cyc();
        dma_done = 1'b1;
        cyc();
        dma_done = 1'b0;
        checks++; if (ch_done !== 4'b0001) begin
            failures++; $display("FAIL en_complete got=%b exp=0001", ch_done); end
        req = 4'b0010;
        bad = 1'b0;
        repeat (10) begin
            cyc();
            if (dma_start !== 1'b0 || dbg_state !== 2'b00 || gnt !== 4'b0000) bad = 1'b1;
        end
        checks++; if (bad) begin
            failures++; $display("FAIL en_hold got activity exp idle while disabled"); end
        enable = 1'b1;
        wait_start(10, n, ok);
        checks++; if (!ok || gnt !== 4'b0010 || dma_len !== 16'd4) begin
            failures++; $display("FAIL en_resume got ok=%0b gnt=%b len=%0d exp 1/0010/4", ok, gnt, dma_len); end
        cyc();
        dma_done = 1'b1;
        cyc();
        dma_done = 1'b0;
        checks++; if (ch_done !== 4'b0010) begin
            failures++; $display("FAIL en_second_done got=%b exp=0010", ch_done); end
        req = '0;
        cyc();
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        do_reset();
        req_len[15:0]  = 16'd2;
        req_len[31:16] = 16'd6;
        req = 4'b0011;
        wait_start(10, n, ok);
        cyc();
        dma_done = 1'b1;
        cyc();
        dma_done = 1'b0;
        req = 4'b0010;
        n = 1;
        while (dma_start !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        checks++; if (n < 3 || n >= 20) begin
            failures++; $display("FAIL b2b_spacing got=%0d exp>=3 and bounded", n); end
        checks++; if (gnt !== 4'b0010) begin
            failures++; $display("FAIL b2b_gnt got=%b exp=0010", gnt); end
        cyc();
        dma_done = 1'b1;
        cyc();
        dma_done = 1'b0;
        req = '0;
        cyc();
    endtask

    task automatic test_rst_mid();
        bit bad;
        do_reset();
        req_addr[31:0] = 32'hABCD_0000;
        req_len[15:0]  = 16'd7;
        req = 4'b0001;
        cyc(); cyc(); cyc();
        checks++; if (dbg_state !== 2'b10) begin
            failures++; $display("FAIL rst_mid_pre got st=%0d exp=2", dbg_state); end
        #2 rst = 1'b1;
        #1;
        checks++; if (gnt !== '0 || dbg_state !== 2'b00 || dma_addr !== '0 || dma_len !== '0 || dma_start !== 1'b0) begin
            failures++; $display("FAIL rst_mid_clear got gnt=%b st=%0d addr=%0h len=%0d exp all 0", gnt, dbg_state, dma_addr, dma_len); end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        cyc();
        dma_done = 1'b1;
        cyc();
        dma_done = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            if (ch_done !== '0 || ch_err !== '0 || dma_abort !== 1'b0 || gnt !== '0 || dbg_state !== 2'b00) bad = 1'b1;
            cyc();
        end
        checks++; if (bad || dbg_xfers !== 16'd0) begin
            failures++; $display("FAIL rst_mid_stray got bad=%0b xfers=%0d exp 0/0", bad, dbg_xfers); end
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] mask;
        int w, k;
        bit e;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                req_addr[c*ADDR_W +: ADDR_W] = $urandom;
                req_len[c*LEN_W +: LEN_W] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 1000));
            end
            mask = 4'($urandom_range(1, 15));
            e    = 1'($urandom_range(0, 1));
            w    = pick(mask, m_ptr);
            req  = mask;
            cyc();
            checks++; if (gnt !== onehot(w)) begin
                failures++; $display("FAIL rnd_gnt it=%0d got=%b exp=%b", it, gnt, onehot(w)); end
            if (req_len[w*LEN_W +: LEN_W] == 16'd0) begin
                checks++; if (ch_done !== onehot(w) || ch_err !== '0 || dma_start !== 1'b0) begin
                    failures++; $display("FAIL rnd_zero it=%0d got done=%b err=%b start=%0b exp %b/0/0", it, ch_done, ch_err, dma_start, onehot(w)); end
            end else begin
                cyc();
                checks++; if (dma_start !== 1'b1 || dma_addr !== req_addr[w*ADDR_W +: ADDR_W] || dma_len !== req_len[w*LEN_W +: LEN_W]) begin
                    failures++; $display("FAIL rnd_start it=%0d got start=%0b addr=%0h len=%0d exp 1/%0h/%0d", it, dma_start, dma_addr, dma_len, req_addr[w*ADDR_W +: ADDR_W], req_len[w*LEN_W +: LEN_W]); end
                k = $urandom_range(1, 20);
                repeat (k) cyc();
                dma_done = 1'b1; dma_err = e;
                cyc();
                dma_done = 1'b0; dma_err = 1'b0;
                checks++; if (ch_done !== (e ? 4'b0000 : onehot(w)) || ch_err !== (e ? onehot(w) : 4'b0000)) begin
                    failures++; $display("FAIL rnd_result it=%0d got done=%b err=%b exp err_flag=%0b ch=%0d", it, ch_done, ch_err, e, w); end
            end
            m_ptr = (w + 1) % NUM_CH;
            m_xfers++;
            req = '0;
            cyc();
        end
        checks++; if (dbg_xfers !== 16'(m_xfers)) begin
            failures++; $display("FAIL rnd_xfers got=%0d exp=%0d", dbg_xfers, m_xfers); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req = '0; req_addr = '0; req_len = '0;
        dma_done = 1'b0; dma_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_err_zero();
        test_enable();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
